// File: rtl/dataflow_input_sync_ctrl_pkg.sv
// Shared defaults and helpers for the dataflow input-process synchroniser.
package dataflow_sync_pkg;

    localparam int STALL_LIMIT_DEF = 1024;
    localparam int VEC_MAX_W       = 64;

    // Callers widen their vector with a size cast so one helper serves any PROC_NUM.
    function automatic logic onehot_or(input logic [VEC_MAX_W-1:0] vec);
        return |vec;
    endfunction

endpackage

// File: rtl/dataflow_input_sync_ctrl_sync_flag_bank.sv
// Per-process sticky flags: set bits accumulate, a clear-all pulse wipes the bank.
module sync_flag_bank #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr_all,
    input  logic [N-1:0] i_set,
    output logic [N-1:0] o_flags
);

    logic [N-1:0] r_flags;

    // Clear-all wins over any set arriving in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= '0;
        end else if (i_clr_all) begin
            r_flags <= '0;
        end else begin
            r_flags <= r_flags | i_set;
        end
    end

    assign o_flags = r_flags;

endmodule

// File: rtl/dataflow_input_sync_ctrl.sv
// Start/ready/done scheduler for the input processes of a dataflow region,
// with an outstanding-iteration limit and a partial-sync stall watchdog.
module dataflow_input_sync_ctrl
    import dataflow_sync_pkg::*;
#(
    parameter int PROC_NUM    = 2,
    parameter int OUTST_MAX   = 4,
    parameter int ITER_W      = 3,
    parameter int STALL_LIMIT = STALL_LIMIT_DEF,
    parameter int STALL_W     = 11
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ap_start,
    input  logic                ap_continue,
    output logic                ap_ready,
    output logic                ap_done,
    output logic                ap_idle,
    output logic [PROC_NUM-1:0] proc_start,
    input  logic [PROC_NUM-1:0] proc_ready,
    input  logic [PROC_NUM-1:0] proc_done,
    input  logic [PROC_NUM-1:0] proc_idle,
    output logic [PROC_NUM-1:0] proc_continue,
    output logic [PROC_NUM-1:0] ready_seen,
    output logic [ITER_W-1:0]   outstanding,
    output logic [PROC_NUM-1:0] stall_vec
);

    logic [ITER_W-1:0]   r_outst;
    logic [STALL_W-1:0]  r_stall_cnt;
    logic [PROC_NUM-1:0] r_stall_vec;

    logic [PROC_NUM-1:0] w_ready_seen;
    logic [PROC_NUM-1:0] w_done_seen;
    logic [PROC_NUM-1:0] w_start;
    logic [PROC_NUM-1:0] w_acc;
    logic                w_full;
    logic                w_all_ready;
    logic                w_ap_ready;
    logic                w_all_done;
    logic                w_ap_done;
    logic                w_retire;
    logic                w_partial;
    logic                w_stall_hit;

    assign w_full      = (r_outst == ITER_W'(OUTST_MAX));
    assign w_start     = {PROC_NUM{ap_start & ~w_full}} & ~w_ready_seen;
    assign w_acc       = w_start & proc_ready;
    assign w_all_ready = &(w_ready_seen | w_acc);
    assign w_ap_ready  = w_all_ready & ap_start & ~w_full;

    assign w_all_done  = &(w_done_seen | proc_done);
    assign w_ap_done   = w_all_done & (r_outst != '0);
    assign w_retire    = w_ap_done & ap_continue;

    assign w_partial   = ap_start & onehot_or(VEC_MAX_W'(w_ready_seen)) & ~w_all_ready;
    assign w_stall_hit = (r_stall_cnt == STALL_W'(STALL_LIMIT));

    sync_flag_bank #(.N(PROC_NUM)) u_ready_bank (
        .clk       (clock),
        .rst_n     (reset),
        .i_clr_all (w_all_ready),
        .i_set     (w_acc),
        .o_flags   (w_ready_seen)
    );

    sync_flag_bank #(.N(PROC_NUM)) u_done_bank (
        .clk       (clock),
        .rst_n     (reset),
        .i_clr_all (w_retire),
        .i_set     (proc_done),
        .o_flags   (w_done_seen)
    );

    // Accept and retire in the same cycle cancel out.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_outst <= '0;
        end else if (w_ap_ready && !w_retire) begin
            r_outst <= r_outst + ITER_W'(1);
        end else if (!w_ap_ready && w_retire) begin
            r_outst <= r_outst - ITER_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (!w_partial) begin
            r_stall_cnt <= '0;
        end else if (!w_stall_hit) begin
            r_stall_cnt <= r_stall_cnt + STALL_W'(1);
        end
    end

    // Sticky report of the processes already waiting on their peers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stall_vec <= '0;
        end else if (w_all_ready) begin
            r_stall_vec <= '0;
        end else if (w_stall_hit && !w_full) begin
            r_stall_vec <= w_ready_seen & proc_idle;
        end
    end

    // Handshake outputs are held low for the whole time reset is asserted.
    assign proc_start    = reset ? w_start : '0;
    assign proc_continue = reset ? {PROC_NUM{ap_continue & w_all_done}} : '0;
    assign ap_ready      = reset & w_ap_ready;
    assign ap_done       = reset & w_ap_done;
    assign ap_idle       = ~ap_start & (r_outst == '0) & (&proc_idle);
    assign ready_seen    = w_ready_seen;
    assign outstanding   = r_outst;
    assign stall_vec     = r_stall_vec;

endmodule

// File: tb/tb_dataflow_input_sync_ctrl.sv
// Self-checking bench for dataflow_input_sync_ctrl: directed scenarios plus an
// ap_ready scoreboard keyed on the cycle each accept is expected.
module tb_dataflow_input_sync_ctrl;

    localparam int PN = 2;
    localparam int OM = 4;
    localparam int IW = 3;
    localparam int SL = 8;
    localparam int SW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          ap_start;
    logic          ap_continue;
    logic          ap_ready;
    logic          ap_done;
    logic          ap_idle;
    logic [PN-1:0] proc_start;
    logic [PN-1:0] proc_ready;
    logic [PN-1:0] proc_done;
    logic [PN-1:0] proc_idle;
    logic [PN-1:0] proc_continue;
    logic [PN-1:0] ready_seen;
    logic [IW-1:0] outstanding;
    logic [PN-1:0] stall_vec;

    dataflow_input_sync_ctrl #(
        .PROC_NUM    (PN),
        .OUTST_MAX   (OM),
        .ITER_W      (IW),
        .STALL_LIMIT (SL),
        .STALL_W     (SW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .ap_start      (ap_start),
        .ap_continue   (ap_continue),
        .ap_ready      (ap_ready),
        .ap_done       (ap_done),
        .ap_idle       (ap_idle),
        .proc_start    (proc_start),
        .proc_ready    (proc_ready),
        .proc_done     (proc_done),
        .proc_idle     (proc_idle),
        .proc_continue (proc_continue),
        .ready_seen    (ready_seen),
        .outstanding   (outstanding),
        .stall_vec     (stall_vec)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    int          exp_out  = 0;
    logic [31:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Every ap_ready pulse must match the next cycle stamp the driver queued.
    always @(negedge clock) begin
        if (ap_ready) begin
            if (exp_q.size() == 0) check_eq("ready_unexpected", 32'(ap_ready), 0);
            else                   check_eq("ready_cycle", cyc, exp_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic adv();
        @(posedge clock);
        #1;
    endtask

    task automatic smp();
        @(negedge clock);
    endtask

    task automatic accept_all();
        ap_start   = 1'b1;
        proc_ready = 2'b11;
        exp_q.push_back(cyc);
        smp();
        check_eq("acc_start", 32'(proc_start), 3);
        adv();
        exp_out++;
        check_eq("acc_outst", 32'(outstanding), exp_out);
        check_eq("acc_seen", 32'(ready_seen), 0);
        ap_start   = 1'b0;
        proc_ready = 2'b00;
    endtask

    task automatic complete_one();
        proc_done   = 2'b11;
        ap_continue = 1'b1;
        smp();
        check_eq("cpl_done", 32'(ap_done), 1);
        check_eq("cpl_cont", 32'(proc_continue), 3);
        adv();
        proc_done   = 2'b00;
        ap_continue = 1'b0;
        exp_out--;
        check_eq("cpl_outst", 32'(outstanding), exp_out);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        reset       = 1'b0;
        ap_start    = 1'b1;
        ap_continue = 1'b1;
        proc_ready  = 2'b11;
        proc_done   = 2'b11;
        proc_idle   = 2'b11;
        smp();
        check_eq("rst_start", 32'(proc_start), 0);
        check_eq("rst_ready", 32'(ap_ready), 0);
        check_eq("rst_done", 32'(ap_done), 0);
        check_eq("rst_cont", 32'(proc_continue), 0);
        check_eq("rst_outst", 32'(outstanding), 0);
        check_eq("rst_seen", 32'(ready_seen), 0);
        check_eq("rst_stall", 32'(stall_vec), 0);
        adv();
        ap_start    = 1'b0;
        ap_continue = 1'b0;
        proc_ready  = 2'b00;
        proc_done   = 2'b00;
        reset       = 1'b1;
        adv();
        check_eq("idle_after_rst", 32'(ap_idle), 1);

        // 1: simultaneous ready from both processes
        ap_start   = 1'b1;
        proc_ready = 2'b11;
        exp_q.push_back(cyc);
        smp();
        check_eq("t1_ready", 32'(ap_ready), 1);
        check_eq("t1_idle", 32'(ap_idle), 0);
        adv();
        exp_out++;
        check_eq("t1_seen", 32'(ready_seen), 0);
        check_eq("t1_outst", 32'(outstanding), exp_out);
        ap_start   = 1'b0;
        proc_ready = 2'b00;

        // 2: staggered ready, process 0 first then process 1 three cycles later
        ap_start   = 1'b1;
        proc_ready = 2'b01;
        smp();
        check_eq("t2_noready", 32'(ap_ready), 0);
        check_eq("t2_start0", 32'(proc_start), 3);
        adv();
        proc_ready = 2'b00;
        smp();
        check_eq("t2_seen", 32'(ready_seen), 1);
        check_eq("t2_start1", 32'(proc_start), 2);
        adv();
        smp();
        check_eq("t2_start2", 32'(proc_start), 2);
        adv();
        proc_ready = 2'b10;
        exp_q.push_back(cyc);
        smp();
        check_eq("t2_start3", 32'(proc_start), 2);
        check_eq("t2_ready", 32'(ap_ready), 1);
        adv();
        exp_out++;
        check_eq("t2_seen_clr", 32'(ready_seen), 0);
        check_eq("t2_outst", 32'(outstanding), exp_out);
        ap_start   = 1'b0;
        proc_ready = 2'b00;

        complete_one();
        complete_one();

        // 3: back-to-back accepts until full, then one retire frees a slot
        ap_start   = 1'b1;
        proc_ready = 2'b11;
        for (int k = 0; k < OM; k++) begin
            exp_q.push_back(cyc);
            smp();
            check_eq("t3_start", 32'(proc_start), 3);
            adv();
            exp_out++;
            check_eq("t3_outst", 32'(outstanding), exp_out);
        end
        smp();
        check_eq("t3_full_start", 32'(proc_start), 0);
        check_eq("t3_full_ready", 32'(ap_ready), 0);
        adv();
        proc_done   = 2'b11;
        ap_continue = 1'b1;
        smp();
        check_eq("t3_done", 32'(ap_done), 1);
        check_eq("t3_full_ready2", 32'(ap_ready), 0);
        adv();
        proc_done   = 2'b00;
        ap_continue = 1'b0;
        exp_out--;
        check_eq("t3_outst_dec", 32'(outstanding), exp_out);
        exp_q.push_back(cyc);
        smp();
        check_eq("t3_fifth_ready", 32'(ap_ready), 1);
        adv();
        exp_out++;
        check_eq("t3_outst_full", 32'(outstanding), exp_out);
        ap_start   = 1'b0;
        proc_ready = 2'b00;

        for (int k = 0; k < 3; k++) complete_one();

        // 4: staggered done held while the consumer stalls
        proc_done = 2'b10;
        smp();
        check_eq("t4_done0", 32'(ap_done), 0);
        check_eq("t4_cont0", 32'(proc_continue), 0);
        adv();
        proc_done = 2'b01;
        smp();
        check_eq("t4_done1", 32'(ap_done), 1);
        check_eq("t4_cont1", 32'(proc_continue), 0);
        adv();
        proc_done = 2'b00;
        smp();
        check_eq("t4_done2", 32'(ap_done), 1);
        adv();
        smp();
        check_eq("t4_done3", 32'(ap_done), 1);
        adv();
        ap_continue = 1'b1;
        smp();
        check_eq("t4_cont", 32'(proc_continue), 3);
        check_eq("t4_done4", 32'(ap_done), 1);
        adv();
        exp_out--;
        check_eq("t4_outst", 32'(outstanding), exp_out);
        smp();
        check_eq("t4_seen_clr", 32'(proc_continue), 0);
        check_eq("t4_done_clr", 32'(ap_done), 0);
        adv();
        ap_continue = 1'b0;

        // 5: process 1 never ready; watchdog flags process 0
        ap_start   = 1'b1;
        proc_ready = 2'b01;
        smp();
        adv();
        proc_ready = 2'b00;
        check_eq("t5_seen", 32'(ready_seen), 1);
        for (int k = 0; k < 7; k++) adv();
        smp();
        check_eq("t5_stall_early", 32'(stall_vec), 0);
        adv();
        adv();
        smp();
        check_eq("t5_stall_set", 32'(stall_vec), 1);
        adv();
        proc_ready = 2'b10;
        exp_q.push_back(cyc);
        smp();
        check_eq("t5_stall_sticky", 32'(stall_vec), 1);
        adv();
        exp_out++;
        check_eq("t5_stall_clr", 32'(stall_vec), 0);
        check_eq("t5_seen_clr", 32'(ready_seen), 0);
        check_eq("t5_outst", 32'(outstanding), exp_out);
        ap_start   = 1'b0;
        proc_ready = 2'b00;

        // 6: reset lands mid-iteration
        accept_all();
        ap_start   = 1'b1;
        proc_ready = 2'b01;
        smp();
        adv();
        proc_ready = 2'b00;
        check_eq("t6_seen", 32'(ready_seen), 1);
        check_eq("t6_outst", 32'(outstanding), exp_out);
        #1;
        reset      = 1'b0;
        proc_ready = 2'b10;
        #1;
        exp_out = 0;
        check_eq("t6_rst_seen", 32'(ready_seen), 0);
        check_eq("t6_rst_outst", 32'(outstanding), exp_out);
        check_eq("t6_rst_start", 32'(proc_start), 0);
        check_eq("t6_rst_ready", 32'(ap_ready), 0);
        smp();
        check_eq("t6_rst_ready2", 32'(ap_ready), 0);
        adv();
        reset      = 1'b1;
        proc_ready = 2'b00;
        smp();
        check_eq("t6_rel_start", 32'(proc_start), 3);
        check_eq("t6_rel_outst", 32'(outstanding), exp_out);
        adv();
        ap_start = 1'b0;
        adv();

        check_eq("ready_q_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dataflow_input_sync_ctrl.md
Name: dataflow_input_sync_ctrl

Overview:
- Start/ready/done scheduler for the input processes of an HLS dataflow region (for example, the Block_proc and zeropad2d processes in myproject).
- Fans the top-level ap_start out to PROC_NUM input processes. Remembers which processes have already accepted the current iteration. Raises top-level ap_ready only when every process has accepted.
- Aggregates per-process done into the top-level ap_done, and tracks how many iterations are outstanding.
- Provides a stall watchdog whose vector feeds the deadlock report unit's dl_in_vec input.

Parameters:
- PROC_NUM, 2, number of synchronised input processes.
- OUTST_MAX, 4, maximum accepted-but-not-done iterations; ap_ready is withheld at this limit.
- ITER_W, 3, width of the outstanding-iteration counter; must satisfy 2^ITER_W > OUTST_MAX.
- STALL_LIMIT, 1024, consecutive partial-sync cycles before the stall flag asserts.
- STALL_W, 11, width of the stall counter; must satisfy 2^STALL_W > STALL_LIMIT.

Ports:
- clock  in  1  design clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ap_start  in  1  top-level start request.
- ap_continue  in  1  top-level consumer accepts the done.
- ap_ready  out  1  top-level iteration accepted (one-cycle pulse).
- ap_done  out  1  top-level iteration complete.
- ap_idle  out  1  region fully idle.
- proc_start  out  PROC_NUM  per-process ap_start.
- proc_ready  in  PROC_NUM  per-process ap_ready.
- proc_done  in  PROC_NUM  per-process ap_done.
- proc_idle  in  PROC_NUM  per-process ap_idle.
- proc_continue  out  PROC_NUM  per-process ap_continue.
- ready_seen  out  PROC_NUM  per-process "ready already given this iteration" flags (ready_count[0] equivalent).
- outstanding  out  ITER_W  number of accepted iterations not yet completed.
- stall_vec  out  PROC_NUM  processes stuck waiting on sync logic; wired to dl_in_vec.

Behaviour:
- Reset (reset low, asynchronous): ready_seen, done_seen, outstanding, stall counter and stall_vec all clear to 0. While reset is low, proc_start, proc_continue, ap_ready and ap_done are forced to 0.
- full = (outstanding == OUTST_MAX).
- proc_start[i] = ap_start & ~ready_seen[i] & ~full.
- Ready accept: acc[i] = proc_start[i] & proc_ready[i].
  - all_ready = &(ready_seen | acc).
  - ap_ready = all_ready & ap_start & ~full. This is combinational, with zero latency from the last proc_ready.
- Ready flag update:
  - On all_ready, ready_seen clears to 0 at the next edge.
  - Otherwise ready_seen |= acc.
  - Simultaneous ready from every process in one cycle: ap_ready asserts that cycle and ready_seen stays 0.
- Done tracking: done_seen[i] sets on proc_done[i].
  - all_done = &(done_seen | proc_done).
  - ap_done = all_done & (outstanding != 0).
  - proc_continue[i] = ap_continue & all_done. Every process is released together.
  - done_seen clears when ap_done & ap_continue.
  - ap_done with ap_continue low holds done_seen and keeps ap_done asserted.
- Outstanding counter:
  - Increment on ap_ready only: +1.
  - Decrement on (ap_done & ap_continue) only: -1.
  - Both in the same cycle: unchanged.
  - It never exceeds OUTST_MAX, because ap_ready is gated by full.
  - It never underflows, because ap_done requires outstanding != 0.
- ap_idle = ~ap_start & (outstanding == 0) & (&proc_idle).
- Stall watchdog:
  - partial = ap_start & (|ready_seen) & ~all_ready.
  - The counter increments while partial, saturating at STALL_LIMIT, and clears when partial is low.
  - When the counter equals STALL_LIMIT, stall_vec <= ready_seen & proc_idle. This is registered and sticky until all_ready or reset.
  - stall_vec is never asserted while full.
- Reset mid-iteration: all flags drop immediately and no ap_ready is emitted. After release, the iteration restarts with every proc_start high.

Decomposition:
- Shared package dataflow_sync_pkg holds:
  - the STALL_LIMIT default;
  - a function onehot_or(vec) returning |vec.
- One natural sub-module, sync_flag_bank: per-process set/clear flag register with the set/clear-all rule above, instantiated twice (ready_seen and done_seen).

Test Plan (PROC_NUM=2, OUTST_MAX=4, STALL_LIMIT=8):
1. Reset release, then ap_start=1 and proc_ready=2'b11 in one cycle -> ap_ready pulses that cycle; ready_seen stays 2'b00; outstanding 0->1.
2. proc_ready=2'b01 at cycle t, then 2'b10 at t+3 -> ready_seen=2'b01 from t+1; proc_start=2'b10 during t+1..t+3; ap_ready pulses at t+3; ready_seen=2'b00 at t+4.
3. Five back-to-back full accepts with no done -> outstanding reaches 4; proc_start=2'b00 and ap_ready=0 on the fifth; one ap_done with ap_continue=1 -> outstanding becomes 3 and the fifth accept proceeds.
4. proc_done=2'b10 then 2'b01 with ap_continue=0 for 3 cycles -> ap_done held high for 3 cycles; proc_continue=2'b11 only when ap_continue rises; done_seen clears on the next edge.
5. Process 0 ready and idle, process 1 never ready -> after 8 partial cycles stall_vec=2'b01; the late proc_ready[1] clears stall_vec on the next edge.
6. Reset asserted with ready_seen=2'b01 and outstanding=2 -> all outputs 0 immediately; after release proc_start=2'b11 and outstanding=0.
